// File: rtl/ring_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ring_arb_pkg
// Brief  : Shared types and one-hot helpers for the ring round-robin arbiter.
// Rev    : 1.0
// ============================================================================
package ring_arb_pkg;

    localparam int c_MAX_N = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic is_onehot(input logic [c_MAX_N-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

    // Rotate left by one within the low n bits; bits above n must be zero.
    function automatic logic [c_MAX_N-1:0] rotl1(input logic [c_MAX_N-1:0] vec,
                                                  input int n);
        logic [c_MAX_N-1:0] mask;
        mask = (n >= c_MAX_N) ? '1 : ((c_MAX_N'(1) << n) - c_MAX_N'(1));
        return ((vec << 1) | (vec >> (n - 1))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational cyclic priority picker starting at a one-hot position.
// Rev    : 1.0
// ============================================================================
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] pos_onehot,
    output logic [N-1:0] win_onehot,
    output logic         any
);

    logic [2*N-1:0] w_dreq;
    logic [2*N-1:0] w_dgnt;

    // Subtracting the position borrows from the first request at/above it,
    // the upper copy supplies the wrap-around.
    assign w_dreq     = {req, req};
    assign w_dgnt     = w_dreq & ~(w_dreq - {{N{1'b0}}, pos_onehot});
    assign win_onehot = w_dgnt[N-1:0] | w_dgnt[2*N-1:N];
    assign any        = |req;

endmodule
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ring_rr_arbiter
// Brief  : Round-robin arbiter with self-repairing one-hot token and hold cap.
// Rev    : 1.0
// ============================================================================
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [N-1:0] token,
    output logic         tok_err
);

    localparam int              c_HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [N-1:0]    c_POS0      = {{(N-1){1'b0}}, 1'b1};

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_grant, w_grant_nxt;
    logic [N-1:0]    r_token, w_token_nxt;
    logic [c_HW-1:0] r_hold,  w_hold_nxt;
    logic            r_tok_err;

    logic [N-1:0]    w_rot, w_pos, w_win;
    logic            w_any, w_tok_ok, w_req_g, w_cap, w_exit;

    assign w_tok_ok = is_onehot(c_MAX_N'(r_token));
    assign w_rot    = N'(rotl1(c_MAX_N'(r_grant), N));
    assign w_req_g  = |(req & r_grant);
    assign w_cap    = (MAX_HOLD != 0) && (r_hold == c_HOLD_LAST);
    assign w_exit   = (r_state == GRANT) && (!w_req_g || w_cap);

    // On exit the search starts after the leaving owner; otherwise at the
    // token, falling back to position 0 while the token is being repaired.
    assign w_pos = w_exit ? w_rot : (w_tok_ok ? r_token : c_POS0);

    rr_pick #(
        .N (N)
    ) u_pick (
        .req        (req),
        .pos_onehot (w_pos),
        .win_onehot (w_win),
        .any        (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_token   <= c_POS0;
            r_hold    <= '0;
            r_tok_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_token   <= w_token_nxt;
            r_hold    <= w_hold_nxt;
            r_tok_err <= !w_tok_ok;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)            w_state_nxt = GRANT;
            GRANT:   if (w_exit && !w_any) w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold;
        w_token_nxt = w_tok_ok ? r_token : c_POS0;
        case (r_state)
            IDLE: begin
                w_grant_nxt = w_win;
                w_hold_nxt  = '0;
            end
            GRANT: begin
                if (w_exit) begin
                    w_token_nxt = w_rot;
                    w_grant_nxt = w_win;
                    w_hold_nxt  = '0;
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign grant   = r_grant;
    assign busy    = |r_grant;
    assign token   = r_token;
    assign tok_err = r_tok_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ring_rr_arbiter
// Brief  : Vector-table bench for ring_rr_arbiter (N=4, MAX_HOLD=4).
// Rev    : 1.0
// ============================================================================
module tb_ring_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [3:0] token;
    logic       busy;
    logic       tok_err;

    typedef struct packed {
        logic       rst;
        logic       frc;
        logic [3:0] req;
        logic [3:0] g;
        logic [3:0] t;
        logic       e;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    ring_rr_arbiter #(
        .N        (4),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .busy    (busy),
        .token   (token),
        .tok_err (tok_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] rq,
                                input logic [3:0] g, input logic [3:0] t, input logic e);
        vec_t v;
        v.rst = r; v.frc = f; v.req = rq; v.g = g; v.t = t; v.e = e;
        return v;
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [3:0] t, input logic e, input int rep);
        for (int i = 0; i < rep; i++) tbl.push_back(mk(r, 1'b0, rq, g, t, e));
    endtask

    task automatic check(input string nm, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst = v.rst;
        req = v.req;
        sb.push_back(v);
        if (v.frc) begin
            force dut.r_token = 4'b0110;
            #4;
            release dut.r_token;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard step %0d: got empty want entry", idx);
        end else begin
            e = sb.pop_front();
            check("grant",   idx, grant,           e.g);
            check("token",   idx, token,           e.t);
            check("busy",    idx, {3'b000, busy},  {3'b000, |e.g});
            check("tok_err", idx, {3'b000, tok_err}, {3'b000, e.e});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int k;
        add(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1);
        add(1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 5);
        // All requesting: 4-cycle tenures rotating with no gaps.
        add(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 4);
        add(1'b0, 4'b1111, 4'b0010, 4'b0010, 1'b0, 4);
        add(1'b0, 4'b1111, 4'b0100, 4'b0100, 1'b0, 4);
        add(1'b0, 4'b1111, 4'b1000, 4'b1000, 1'b0, 4);
        add(1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1);
        add(1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1);
        // Short request of two cycles.
        add(1'b0, 4'b0100, 4'b0100, 4'b0010, 1'b0, 2);
        add(1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2);
        // Lone requester: forced revoke then immediate re-grant.
        add(1'b0, 4'b0010, 4'b0010, 4'b1000, 1'b0, 4);
        add(1'b0, 4'b0010, 4'b0010, 4'b0100, 1'b0, 6);
        add(1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1);

        k = 0;
        foreach (tbl[i]) begin
            step(tbl[i], k);
            k++;
        end

        // Token corruption mid-tenure.
        step(mk(1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0100, 1'b0), k++);
        step(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 4'b0001, 1'b1), k++);
        step(mk(1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0001, 1'b0), k++);
        step(mk(1'b0, 1'b0, 4'b1111, 4'b1000, 4'b0001, 1'b0), k++);
        // Reset during a grant of 1000, then restart from position 0.
        step(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0), k++);
        step(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0), k++);
        step(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0), k++);
        step(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0), k++);
        step(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b0), k++);
        // Owner drops on the same cycle the cap is reached: single exit.
        step(mk(1'b0, 1'b0, 4'b1110, 4'b0010, 4'b0010, 1'b0), k++);
        step(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0), k++);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters, with priority carried by a one-hot token that rotates like a ring counter. The token is self-seeding from reset, so it needs no forced load. It also self-correcting: any illegal (zero or multi-hot) token is repaired on the next edge. The block sits in front of shared datapath resources and issues a registered one-hot grant with a bounded hold time.

## Interface
- N, default 4: number of requesters; minimum 2.
- MAX_HOLD, default 8: maximum consecutive grant cycles per tenure; 0 means unlimited.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; a requester holds its bit high for as long as it wants the resource.
- grant  output  N  registered one-hot grant, or all zeros.
- busy  output  1  high when grant is non-zero.
- token  output  N  current priority pointer (one-hot), exposed for debug.
- tok_err  output  1  one-cycle pulse when an illegal token was detected and repaired.

## Operation
- States:
  - IDLE: grant = 0.
  - GRANT: grant = onehot(g).
- Pick function: the winner is the first index i with req[i]=1, scanning cyclically from the token position upward (pos, pos+1, … wrapping to pos-1).
- IDLE → GRANT: when req != 0, load grant with the picked index and clear hold_cnt.
- GRANT exit condition (evaluated every cycle): req[g]=0, or (MAX_HOLD≠0 and hold_cnt == MAX_HOLD-1).
- On exit:
  - token <= rotate-left-by-1 of onehot(g), i.e. the position after g.
  - The pick is re-evaluated in the same cycle using that new position and the current req.
  - If any request exists, grant switches directly to the new winner with no idle gap. Otherwise the block goes to IDLE.
- Forced revoke (hold cap reached while req[g] is still 1): g becomes lowest priority.
  - If g is the only requester, it is re-granted at the next edge and hold_cnt restarts at 0.
- No exit: grant is held and hold_cnt increments, saturating at MAX_HOLD-1. With MAX_HOLD=0 the counter is unused.
- Token integrity is checked every cycle.
  - If token is not one-hot, token <= 1 at the next edge and tok_err pulses for one cycle.
  - In that cycle the arbitration uses position 0.
  - An existing grant is unaffected.
- The grant output is always one-hot or zero, including after token repair.

## Timing
- Reset values: grant=0, busy=0, token=1 (bit 0), tok_err=0, state=IDLE, hold_cnt=0.
- A reset asserted mid-tenure drops grant at the next edge, with no release handshake.
- Latency from req rising (sampled at edge k) to grant high is 1 cycle (grant visible after edge k).
- Latency from req[g] falling to grant[g] falling is 1 cycle. A competing winner's grant rises on the same edge.
- A requester that drops and re-raises req within one cycle is treated as a new request and is subject to rotation.
- hold_cnt width is clog2(MAX_HOLD+1). A tenure lasts at most MAX_HOLD cycles.
- If req[g] drops at the same cycle as the hold cap is reached, this is a single exit: the token moves to g+1 and tok_err is unaffected.
- req bits are assumed synchronous to clk; they are not synchronized internally.

## Structure
- Shared package ring_arb_pkg contains:
  - state enum (IDLE, GRANT);
  - function is_onehot(vec);
  - function rotl1(vec).
- One sub-module, rr_pick: combinational picker with inputs req[N] and pos_onehot[N], and outputs win_onehot[N] and any.
  - It uses the double-width masked priority trick.
  - The top level instantiates it once.
- Top level contains the token register, FSM, hold counter and output registers. Expected size is about 150–250 lines total.

## Test plan
All scenarios use N=4 and MAX_HOLD=4.
- Reset, then req=0000 for 5 cycles → grant=0000, token=0001, busy=0, tok_err=0 throughout.
- req=1111 held constant → grant sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles, no gap cycles; token advances after each tenure.
- req=0100 raised for 2 cycles then dropped → grant=0100 one cycle after rise, for 2 cycles, then 0000; token=1000.
- req=0010 held alone for 10 cycles → grant=0010 continuously (forced revoke, then re-grant); hold_cnt wraps at 3.
- Force token=0110 mid-tenure, then release → tok_err pulses once, token=0001 next cycle, current grant is unchanged.
- Assert rst during a grant of 1000 with req=1111 → grant=0000 next cycle; after rst is released, the first grant is 0001.
